// File: rtl/i2s_tx_fifo.sv
// I2S transmitter with a frame FIFO; Philips framing, left word first.
// Optional build macro I2S_TX_MONO_EN: one sample per entry, sent in both slots.
module i2s_tx_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 8,
`ifdef I2S_TX_MONO_EN
  localparam int IN_W      = SAMPLE_W,
`else
  localparam int IN_W      = 2*SAMPLE_W,
`endif
  localparam int LVL_W     = $clog2(FIFO_DEPTH)+1
) (
  input  logic             MasterCLK,
  input  logic             Reset,
  input  logic [IN_W-1:0]  InputData,
  input  logic             InputValid,
  output logic             InputReady,
  input  logic             Enable,
  output logic             SyncCLK,
  output logic             I2S_CLK,
  output logic             I2S_WS,
  output logic             I2S_DATA,
  output logic             Underrun,
  output logic [LVL_W-1:0] Level
);
  localparam int FRM_W = 2*SAMPLE_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int B_W   = $clog2(FRM_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [B_W-1:0]    b_q;
  logic [FRM_W-1:0]  sh_q;
  logic [FRM_W-1:0]  pop_frame;
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [LVL_W-1:0]  count_q;
  logic [IN_W-1:0]   mem [FIFO_DEPTH];
  logic              fall, frame_start, push, pop;

  assign fall       = Enable && (div_q == DIV_W'(CLK_DIV-1));
  assign InputReady = (count_q != LVL_W'(FIFO_DEPTH));
  assign push       = InputValid && InputReady;
  assign pop        = frame_start && (count_q != '0);
  assign Level      = count_q;

  assign I2S_CLK  = (div_q >= DIV_W'(CLK_DIV/2));
  assign I2S_WS   = (b_q >= B_W'(SAMPLE_W-1)) && (b_q <= B_W'(FRM_W-2));
  assign I2S_DATA = sh_q[FRM_W-1];

`ifdef I2S_TX_MONO_EN
  assign pop_frame = {mem[rd_q], mem[rd_q]};
`else
  assign pop_frame = mem[rd_q];
`endif

  // IDLE covers the gap between Enable rising and the first fall tick,
  // where b is still 0 but the tick must be treated as a frame start.
  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (fall) state_d = RUN;
      RUN:     if (!Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_start = fall && ((state == IDLE) || (b_q == B_W'(FRM_W-1)));
  end

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      div_q    <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      SyncCLK  <= 1'b0;
      Underrun <= 1'b0;
    end else if (!Enable) begin
      div_q    <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      SyncCLK  <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      div_q   <= fall ? '0 : div_q + 1'b1;
      SyncCLK <= frame_start;
      if (frame_start) begin
        b_q <= '0;
        if (count_q != '0) begin
          sh_q <= pop_frame;
        end else begin
          sh_q     <= '0;
          Underrun <= 1'b1;
        end
      end else if (fall) begin
        b_q  <= b_q + 1'b1;
        sh_q <= {sh_q[FRM_W-2:0], 1'b0};
      end
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (push) mem[wr_q] <= InputData;
  end
endmodule

// File: doc/i2s_tx_fifo.md
I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 SAMPLE_W, 16, bits per channel sample (8..32).
REQ-002 FIFO_DEPTH, 8, frame entries, power of two, >=2.
REQ-003 CLK_DIV, 8, MasterCLK cycles per I2S_CLK period, even, >=2.
REQ-004 MasterCLK  in  1  single system clock; all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 InputData  in  2*SAMPLE_W (SAMPLE_W with REQ-031)  frame; upper half = left, lower half = right.
REQ-007 InputValid  in  1  InputData valid.
REQ-008 InputReady  out  1  FIFO not full.
REQ-009 Enable  in  1  serial output run.
REQ-010 SyncCLK  out  1  one-cycle pulse at every frame start.
REQ-011 I2S_CLK  out  1  serial bit clock.
REQ-012 I2S_WS  out  1  word select, 0 = left.
REQ-013 I2S_DATA  out  1  serial data, MSB first.
REQ-014 Underrun  out  1  sticky: frame start found FIFO empty.
REQ-015 Level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-016 Write occurs when InputValid && InputReady; InputReady = (Level != FIFO_DEPTH), driven from registers.
REQ-017 Divider counter runs 0..CLK_DIV-1 while Enable=1; I2S_CLK = 0 for counts 0..CLK_DIV/2-1, 1 otherwise; "fall tick" = cycle the counter wraps to 0.
REQ-018 Slot counter b runs 0..2*SAMPLE_W-1, advancing one per fall tick, wrapping to 0.
REQ-019 Frame start = fall tick entering b=0; SyncCLK pulses in that cycle only.
REQ-020 At frame start, if Level>0: pop head into shift register; else load zero and set Underrun.
REQ-021 I2S_DATA during slot b = bit (2*SAMPLE_W-1-b) of loaded frame; changes only on fall ticks.
REQ-022 I2S_WS during slot b = 1 iff SAMPLE_W-1 <= b <= 2*SAMPLE_W-2 (one-slot lead, Philips I2S).
REQ-023 Simultaneous write and pop: both take effect; Level unchanged.
REQ-024 Write arriving in the same cycle as a frame start with Level=0: frame is zero, Underrun set, written entry kept for next frame.
REQ-025 Enable=0: divider, b, I2S_CLK, I2S_WS, I2S_DATA held at 0; Underrun cleared; FIFO still accepts writes and retains contents.
REQ-026 Enable 0->1: first fall tick (frame start, b=0) occurs CLK_DIV cycles after first cycle with Enable=1.
REQ-027 Enable dropping mid-frame aborts immediately; current frame discarded; no pop until next frame start.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH; Level never exceeds FIFO_DEPTH nor underflows.

Reset
REQ-029 Reset asserted: I2S_CLK, I2S_WS, I2S_DATA, SyncCLK, Underrun = 0; Level = 0; InputReady = 1; pointers, counters, shift register = 0; FIFO contents discarded.
REQ-030 Reset mid-frame takes effect without waiting for a clock edge; after release, behaviour as REQ-026 if Enable=1.

Configuration
REQ-031 I2S_TX_MONO_EN defined: InputData is SAMPLE_W wide, FIFO stores SAMPLE_W per entry, the popped sample is transmitted in both left and right slots; undefined: stereo per REQ-006.

Verification
REQ-032 Defaults, write 0x1234_ABCD, Enable=1 -> SyncCLK at cycle 8, left slots 0x1234, right 0xABCD MSB first, WS rises at slot 15, 256 cycles per frame.
REQ-033 Write 9 frames with Enable=0 -> first 8 accepted, InputReady=0, Level=8; 9th held until a pop.
REQ-034 Enable=1 with empty FIFO -> DATA all 0 for frame, Underrun=1 until Enable=0.
REQ-035 Continuous InputValid at a frame start with Level=8 -> pop and no write that cycle, write next cycle, Level stays 8.
REQ-036 Reset asserted at slot 10 -> all outputs 0 same cycle, Level=0, InputReady=1.
REQ-037 I2S_TX_MONO_EN, write 0x00FF -> left and right slots both 0x00FF.
